solve_result_collector: RTL
===========================

Name: solve_result_collector

Overview:
- Sits directly downstream of the Othello solver pipeline.
- Captures each solved pulse together with its board, final score and context id, and buffers the records in a FIFO.
- Presents the records to the host side over a valid/ready interface.
- Keeps sticky error flags and saturating win/loss/draw statistics.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
AW, 4, log2(DEPTH)
AF_LEVEL, 12, fill level at or above which oALMOST_FULL asserts
CNT_W, 16, width of each statistics counter

Ports:
iCLOCK  in  1  system clock, rising edge
iRESET  in  1  asynchronous, active-high reset
iSOLVED  in  1  solver solved strobe; one cycle per finished task
iPLAYER  in  64  solver oPlayer, valid when iSOLVED=1
iOPPONENT  in  64  solver oOpponent, valid when iSOLVED=1
iRES  in  8  solver res (signed), valid when iSOLVED=1
iCTX  in  5  solver o; bits [2:0] hold the context id, valid one cycle after iSOLVED
iCLEAR  in  1  synchronous clear of counters and sticky flags; FIFO contents are kept
oVALID  out  1  head record available
iREADY  in  1  consumer accepts head when oVALID=1
oPLAYER  out  64  head record player bitboard
oOPPONENT  out  64  head record opponent bitboard
oRES  out  8  head record score (signed)
oCTX  out  3  head record context id
oCOUNT  out  AW+1  FIFO fill level, 0..DEPTH
oALMOST_FULL  out  1  oCOUNT >= AF_LEVEL
oOVERFLOW  out  1  sticky: a record was dropped
oRANGE_ERR  out  1  sticky: a captured iRES was outside -64..64
oWINS  out  CNT_W  count of records with res>0, saturating
oLOSSES  out  CNT_W  count of records with res<0, saturating
oDRAWS  out  CNT_W  count of records with res==0, saturating

Behaviour:
- Reset (async, iRESET=1): FIFO empty, oVALID=0, oCOUNT=0, all flags 0, all counters 0. Data outputs are 0.
- Any reset asserted mid-stream discards all buffered records and any record held in the align stage.
- Align stage (S1):
  - On a cycle with iSOLVED=1, register {iPLAYER, iOPPONENT, iRES} and set s1_v=1.
  - In the following cycle, take iCTX[2:0] and form the 139-bit record {player, opponent, res, ctx}.
  - That record becomes the push request for the edge ending that cycle.
- Back-to-back iSOLVED pulses are legal and must not lose data: S1 is single-entry and is overwritten every cycle.
- The context id for pulse k is always the iCTX sampled in the cycle after pulse k.
- Latency: iSOLVED high in cycle N -> record written at the end of N+1 -> oVALID=1 in N+2 if the FIFO was empty.
- FIFO:
  - Register-based and first-word-fall-through; head outputs are driven from storage at the read pointer.
  - Pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from oCOUNT.
  - Pop occurs when oVALID & iREADY.
  - Push occurs when the request is present and (oCOUNT<DEPTH or pop occurs this cycle).
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Full without a pop: the record is dropped and oOVERFLOW is set. The statistics still count the dropped record.
  - Empty FIFO: iREADY is ignored; simultaneous push and pop cannot happen because oVALID=0.
  - Head data is held stable while oVALID=1 and iREADY=0.
- Statistics:
  - Updated on every push request, accepted or dropped.
  - Classification uses signed iRES: res>0 increments oWINS, res<0 increments oLOSSES, res==0 increments oDRAWS.
  - Each counter saturates at all ones.
  - oRANGE_ERR sets if res<-64 or res>64; the record is still pushed.
- iCLEAR:
  - Zeroes the counters and both sticky flags at the next edge.
  - If a push request coincides with iCLEAR, clear wins and the event is not counted. The record itself is still pushed.
- oALMOST_FULL is combinational from oCOUNT.
- oCOUNT equals the number of stored entries, excluding the S1 stage.

Test Plan:
- Single pulse: iSOLVED in cycle 10 with res=+12, iPLAYER=64'h0000_0000_FFFF_0000, iCTX=3 in cycle 11 -> oVALID=1 in cycle 12 with matching data, oCTX=3, oWINS=1.
- Burst of 7 consecutive pulses (ctx 0..6, res -64,-2,0,0,5,64,-1) with iREADY=0 -> oCOUNT=7; oWINS=2, oLOSSES=3, oDRAWS=2; draining returns the records in order with the correct ctx.
- Overflow: DEPTH+2 pulses with iREADY=0 -> oCOUNT=16, oOVERFLOW=1, the first 16 records are retained, oWINS+oLOSSES+oDRAWS=18.
- Full with simultaneous pop: fill to 16, then hold iREADY=1 during a pulse -> oCOUNT stays 16, oOVERFLOW stays 0, the new record appears last.
- Range and clear: res=8'sd100 -> oRANGE_ERR=1; iCLEAR for one cycle -> counters and flags 0, oCOUNT unchanged.
- Async reset asserted between a pulse and its ctx cycle -> all outputs 0 immediately; after release no record appears.

Source files
------------

// File: rtl/solve_result_collector.sv
// Collects solved Othello results: aligns each result with its late context id,
// buffers records in a first-word-fall-through FIFO and keeps result statistics.
module solve_result_collector #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12,
  parameter int CNT_W    = 16
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iSOLVED,
  input  logic [63:0]      iPLAYER,
  input  logic [63:0]      iOPPONENT,
  input  logic [7:0]       iRES,
  input  logic [4:0]       iCTX,
  input  logic             iCLEAR,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [63:0]      oPLAYER,
  output logic [63:0]      oOPPONENT,
  output logic [7:0]       oRES,
  output logic [2:0]       oCTX,
  output logic [AW:0]      oCOUNT,
  output logic             oALMOST_FULL,
  output logic             oOVERFLOW,
  output logic             oRANGE_ERR,
  output logic [CNT_W-1:0] oWINS,
  output logic [CNT_W-1:0] oLOSSES,
  output logic [CNT_W-1:0] oDRAWS
);

  localparam int                RW         = 139;
  localparam logic [AW:0]       FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]       AF_THRESH  = (AW+1)'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic signed [7:0] RES_MAX    = 8'sd64;
  localparam logic signed [7:0] RES_MIN    = -8'sd64;

  logic              s1_v_q, s1_v_d;
  logic [63:0]       s1_player_q, s1_player_d;
  logic [63:0]       s1_opponent_q, s1_opponent_d;
  logic [7:0]        s1_res_q, s1_res_d;

  logic [RW-1:0]     mem_q [DEPTH];
  logic [RW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  logic              overflow_q, overflow_d;
  logic              range_err_q, range_err_d;
  logic [CNT_W-1:0]  wins_q, wins_d;
  logic [CNT_W-1:0]  losses_q, losses_d;
  logic [CNT_W-1:0]  draws_q, draws_d;

  logic              push_req;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [RW-1:0]     record;
  logic [RW-1:0]     head;
  logic signed [7:0] res_s;
  logic              unused_ctx;

  // The context id arrives one cycle late, so the record is completed from
  // the align stage plus the live iCTX.
  assign push_req   = s1_v_q;
  assign record     = {s1_player_q, s1_opponent_q, s1_res_q, iCTX[2:0]};
  assign res_s      = s1_res_q;
  assign unused_ctx = ^iCTX[4:3];

  assign fifo_full  = (count_q == FULL_LEVEL);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && iREADY;
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    s1_v_d        = iSOLVED;
    s1_player_d   = s1_player_q;
    s1_opponent_d = s1_opponent_q;
    s1_res_d      = s1_res_q;
    if (iSOLVED) begin
      s1_player_d   = iPLAYER;
      s1_opponent_d = iOPPONENT;
      s1_res_d      = iRES;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = record;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Statistics see every push request, including ones the full FIFO drops;
  // a coincident clear takes priority and the event goes uncounted.
  always_comb begin
    overflow_d  = overflow_q;
    range_err_d = range_err_q;
    wins_d      = wins_q;
    losses_d    = losses_q;
    draws_d     = draws_q;
    if (iCLEAR) begin
      overflow_d  = 1'b0;
      range_err_d = 1'b0;
      wins_d      = '0;
      losses_d    = '0;
      draws_d     = '0;
    end else if (push_req) begin
      if (fifo_full && !pop) begin
        overflow_d = 1'b1;
      end
      if (res_s > RES_MAX || res_s < RES_MIN) begin
        range_err_d = 1'b1;
      end
      if (res_s > 8'sd0) begin
        if (wins_q != CNT_MAX) wins_d = wins_q + CNT_W'(1);
      end else if (res_s < 8'sd0) begin
        if (losses_q != CNT_MAX) losses_d = losses_q + CNT_W'(1);
      end else begin
        if (draws_q != CNT_MAX) draws_d = draws_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      s1_v_q        <= 1'b0;
      s1_player_q   <= '0;
      s1_opponent_q <= '0;
      s1_res_q      <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      range_err_q   <= 1'b0;
      wins_q        <= '0;
      losses_q      <= '0;
      draws_q       <= '0;
    end else begin
      s1_v_q        <= s1_v_d;
      s1_player_q   <= s1_player_d;
      s1_opponent_q <= s1_opponent_d;
      s1_res_q      <= s1_res_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      range_err_q   <= range_err_d;
      wins_q        <= wins_d;
      losses_q      <= losses_d;
      draws_q       <= draws_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign oVALID       = !fifo_empty;
  assign oPLAYER      = head[138:75];
  assign oOPPONENT    = head[74:11];
  assign oRES         = head[10:3];
  assign oCTX         = head[2:0];
  assign oCOUNT       = count_q;
  assign oALMOST_FULL = (count_q >= AF_THRESH);
  assign oOVERFLOW    = overflow_q;
  assign oRANGE_ERR   = range_err_q;
  assign oWINS        = wins_q;
  assign oLOSSES      = losses_q;
  assign oDRAWS       = draws_q;

endmodule
